// File: rtl/seg7_scan_disp.sv
// N-digit time-multiplexed seven-segment driver with frame-synchronous double buffering,
// guard blanking at each digit switch and optional leading-zero suppression.
module seg7_scan_disp #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned FRAME_HZ     = 250,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    data_valid,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int unsigned TICK_DIV = CLK_HZ / (FRAME_HZ * NUM_DIGITS);
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW       = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] GUARD    = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  if (TICK_DIV < GUARD_CYCLES + 2) begin : g_tick_div_check
    $error("seg7_scan_disp: TICK_DIV too small for GUARD_CYCLES");
  end

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_num_digits_check
    $error("seg7_scan_disp: NUM_DIGITS must be 1..8");
  end

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         pend_buf;
  logic [DW-1:0]         disp_buf;
  logic                  tick;
  logic                  frame_wrap;
  logic [3:0]            nib;
  logic [6:0]            font;
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  blank;
  logic [6:0]            seg_hi;
  logic [NUM_DIGITS-1:0] en_hi;

  always_comb begin
    tick       = (pcnt == PCNT_MAX);
    frame_wrap = tick && (idx == IDX_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt     <= '0;
      idx      <= '0;
      pend_buf <= '0;
      disp_buf <= '0;
    end else begin
      if (tick) begin
        pcnt <= '0;
        idx  <= frame_wrap ? '0 : idx + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
      if (data_valid) begin
        pend_buf <= data;
      end
      // A strobe landing on the boundary bypasses pend_buf so it shows without a frame of lag.
      if (frame_wrap) begin
        disp_buf <= data_valid ? data : pend_buf;
      end
    end
  end

  // zero_from[i]: nibble i and every nibble above it are zero.
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (disp_buf[DW-4 +: 4] == 4'h0);
    for (int unsigned j = 2; j <= NUM_DIGITS; j++) begin
      zero_from[NUM_DIGITS-j] = (disp_buf[4*(NUM_DIGITS-j) +: 4] == 4'h0)
                                && zero_from[NUM_DIGITS-j+1];
    end
  end

  always_comb begin
    nib   = disp_buf[4*idx +: 4];
    blank = LZ_BLANK && (idx != '0) && zero_from[idx];
  end

  always_comb begin
    case (nib)
      4'h0:    font = 7'h3F;
      4'h1:    font = 7'h06;
      4'h2:    font = 7'h5B;
      4'h3:    font = 7'h4F;
      4'h4:    font = 7'h66;
      4'h5:    font = 7'h6D;
      4'h6:    font = 7'h7D;
      4'h7:    font = 7'h07;
      4'h8:    font = 7'h7F;
      4'h9:    font = 7'h6F;
      4'hA:    font = 7'h77;
      4'hB:    font = 7'h7C;
      4'hC:    font = 7'h39;
      4'hD:    font = 7'h5E;
      4'hE:    font = 7'h79;
      default: font = 7'h71;
    endcase
  end

  always_comb begin
    seg_hi = blank ? '0 : font;
    en_hi  = '0;
    if (pcnt >= GUARD) begin
      en_hi[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segments    <= {7{ACTIVE_LOW}};
      digit_en    <= {NUM_DIGITS{ACTIVE_LOW}};
      frame_start <= 1'b0;
    end else begin
      segments    <= seg_hi ^ {7{ACTIVE_LOW}};
      digit_en    <= en_hi ^ {NUM_DIGITS{ACTIVE_LOW}};
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_disp.sv
// Bench for seg7_scan_disp: 4 digits, TICK_DIV=8, active-low, with and without leading-zero blanking.
module tb_seg7_scan_disp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic        data_valid = 1'b0;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_start;
  logic [6:0]  segments_nl;
  logic [3:0]  digit_en_nl;
  logic        frame_start_nl;

  int unsigned test_count = 0;
  int unsigned fail_count = 0;

  typedef struct {
    string       name;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}, 7 bits each
  } exp_t;
  exp_t exp_q[$];

  logic [6:0]  cap_seg [4];
  logic [6:0]  cap_seg_nl [4];
  logic [3:0]  cap_en [4];
  logic [3:0]  cap_en_nl [4];
  int unsigned cap_fs_count;
  logic        cap_fs_last;
  logic        cap_fs_nl_last;

  always #5 clk = ~clk;

  seg7_scan_disp #(
    .NUM_DIGITS(4), .CLK_HZ(8000), .FRAME_HZ(250),
    .GUARD_CYCLES(2), .ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .segments(segments), .digit_en(digit_en), .frame_start(frame_start)
  );

  seg7_scan_disp #(
    .NUM_DIGITS(4), .CLK_HZ(8000), .FRAME_HZ(250),
    .GUARD_CYCLES(2), .ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)
  ) dut_nolz (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .segments(segments_nl), .digit_en(digit_en_nl), .frame_start(frame_start_nl)
  );

  // Entered just after the negedge on which frame_start was seen; observes the next 32 cycles,
  // sampling each digit slot mid-way, with optional data_valid strobes at frame positions k.
  task automatic capture_frame(input int unsigned k1, input logic [15:0] d1,
                               input int unsigned k2, input logic [15:0] d2);
    cap_fs_count = 0;
    for (int unsigned k = 1; k <= 32; k++) begin
      @(negedge clk);
      if ((k - 1) % 8 == 4) begin
        cap_seg[(k-1)/8]    = segments;
        cap_seg_nl[(k-1)/8] = segments_nl;
        cap_en[(k-1)/8]     = digit_en;
        cap_en_nl[(k-1)/8]  = digit_en_nl;
      end
      if (frame_start) cap_fs_count++;
      cap_fs_nl_last = frame_start_nl;
      data_valid = (k == k1) || (k == k2);
      if (k == k1) data = d1;
      if (k == k2) data = d2;
    end
    cap_fs_last = frame_start;
  endtask

  task automatic test_reset();
    logic [3:0]  one = 4'b0001;
    logic [3:0]  exp_en;
    logic [6:0]  exp_seg;
    logic        exp_fs;
    int unsigned slot;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_count++;
    if (segments !== 7'h7F) begin fail_count++; $display("FAIL reset_segments got %h expected 7f", segments); end
    test_count++;
    if (digit_en !== 4'hF) begin fail_count++; $display("FAIL reset_digit_en got %b expected 1111", digit_en); end
    test_count++;
    if (frame_start !== 1'b0) begin fail_count++; $display("FAIL reset_frame_start got %b expected 0", frame_start); end
    rst = 1'b0;
    for (int unsigned c = 0; c < 64; c++) begin
      @(negedge clk);
      slot    = (c / 8) % 4;
      exp_en  = ((c % 8) < 2) ? 4'hF : ~(one << slot);
      exp_seg = (slot == 0) ? 7'h40 : 7'h7F;
      exp_fs  = ((c % 32) == 31);
      test_count++;
      if (digit_en !== exp_en) begin
        fail_count++; $display("FAIL idle_digit_en cycle %0d got %b expected %b", c, digit_en, exp_en);
      end
      test_count++;
      if (segments !== exp_seg) begin
        fail_count++; $display("FAIL idle_segments cycle %0d got %h expected %h", c, segments, exp_seg);
      end
      test_count++;
      if (frame_start !== exp_fs) begin
        fail_count++; $display("FAIL idle_frame_start cycle %0d got %b expected %b", c, frame_start, exp_fs);
      end
    end
  endtask

  task automatic test_mid_frame_update();
    exp_t e;
    logic [3:0] one = 4'b0001;
    exp_q.push_back('{name: "old_frame", segs: {7'h7F, 7'h7F, 7'h7F, 7'h40}});
    capture_frame(10, 16'h0A3F, 0, 16'h0000);
    exp_q.push_back('{name: "new_0A3F", segs: {7'h7F, 7'h08, 7'h30, 7'h0E}});
    e = exp_q.pop_front();
    for (int unsigned d = 0; d < 4; d++) begin
      test_count++;
      if (cap_seg[d] !== e.segs[7*d +: 7]) begin
        fail_count++; $display("FAIL %s digit%0d segments got %h expected %h", e.name, d, cap_seg[d], e.segs[7*d +: 7]);
      end
    end
    capture_frame(0, 16'h0000, 0, 16'h0000);
    e = exp_q.pop_front();
    for (int unsigned d = 0; d < 4; d++) begin
      test_count++;
      if (cap_seg[d] !== e.segs[7*d +: 7]) begin
        fail_count++; $display("FAIL %s digit%0d segments got %h expected %h", e.name, d, cap_seg[d], e.segs[7*d +: 7]);
      end
      test_count++;
      if (cap_en[d] !== ~(one << d)) begin
        fail_count++; $display("FAIL %s digit%0d digit_en got %b expected %b", e.name, d, cap_en[d], ~(one << d));
      end
    end
    test_count++;
    if (cap_fs_count !== 1 || cap_fs_last !== 1'b1) begin
      fail_count++; $display("FAIL mid_frame_fs pulses got %0d last %b expected 1 last 1", cap_fs_count, cap_fs_last);
    end
  endtask

  task automatic test_last_strobe_wins();
    exp_t e;
    exp_q.push_back('{name: "before_beef", segs: {7'h7F, 7'h08, 7'h30, 7'h0E}});
    capture_frame(4, 16'h1234, 20, 16'hBEEF);
    exp_q.push_back('{name: "beef", segs: {7'h03, 7'h06, 7'h06, 7'h0E}});
    e = exp_q.pop_front();
    for (int unsigned d = 0; d < 4; d++) begin
      test_count++;
      if (cap_seg[d] !== e.segs[7*d +: 7]) begin
        fail_count++; $display("FAIL %s digit%0d segments got %h expected %h", e.name, d, cap_seg[d], e.segs[7*d +: 7]);
      end
    end
    capture_frame(0, 16'h0000, 0, 16'h0000);
    e = exp_q.pop_front();
    for (int unsigned d = 0; d < 4; d++) begin
      test_count++;
      if (cap_seg[d] !== e.segs[7*d +: 7]) begin
        fail_count++; $display("FAIL %s digit%0d segments got %h expected %h", e.name, d, cap_seg[d], e.segs[7*d +: 7]);
      end
    end
  endtask

  task automatic test_wrap_cycle_strobe();
    exp_t e;
    exp_q.push_back('{name: "before_wrap", segs: {7'h03, 7'h06, 7'h06, 7'h0E}});
    capture_frame(31, 16'h7A5C, 0, 16'h0000);
    exp_q.push_back('{name: "wrap_7A5C", segs: {7'h78, 7'h08, 7'h12, 7'h46}});
    e = exp_q.pop_front();
    for (int unsigned d = 0; d < 4; d++) begin
      test_count++;
      if (cap_seg[d] !== e.segs[7*d +: 7]) begin
        fail_count++; $display("FAIL %s digit%0d segments got %h expected %h", e.name, d, cap_seg[d], e.segs[7*d +: 7]);
      end
    end
    capture_frame(0, 16'h0000, 0, 16'h0000);
    e = exp_q.pop_front();
    for (int unsigned d = 0; d < 4; d++) begin
      test_count++;
      if (cap_seg[d] !== e.segs[7*d +: 7]) begin
        fail_count++; $display("FAIL %s digit%0d segments got %h expected %h", e.name, d, cap_seg[d], e.segs[7*d +: 7]);
      end
    end
  endtask

  task automatic test_lz_blank();
    exp_t e;
    logic [3:0] one = 4'b0001;
    capture_frame(6, 16'h0000, 0, 16'h0000);
    exp_q.push_back('{name: "zero_lz", segs: {7'h7F, 7'h7F, 7'h7F, 7'h40}});
    exp_q.push_back('{name: "zero_nolz", segs: {7'h40, 7'h40, 7'h40, 7'h40}});
    capture_frame(0, 16'h0000, 0, 16'h0000);
    e = exp_q.pop_front();
    for (int unsigned d = 0; d < 4; d++) begin
      test_count++;
      if (cap_seg[d] !== e.segs[7*d +: 7]) begin
        fail_count++; $display("FAIL %s digit%0d segments got %h expected %h", e.name, d, cap_seg[d], e.segs[7*d +: 7]);
      end
    end
    e = exp_q.pop_front();
    for (int unsigned d = 0; d < 4; d++) begin
      test_count++;
      if (cap_seg_nl[d] !== e.segs[7*d +: 7]) begin
        fail_count++; $display("FAIL %s digit%0d segments got %h expected %h", e.name, d, cap_seg_nl[d], e.segs[7*d +: 7]);
      end
      test_count++;
      if (cap_en_nl[d] !== ~(one << d)) begin
        fail_count++; $display("FAIL %s digit%0d digit_en got %b expected %b", e.name, d, cap_en_nl[d], ~(one << d));
      end
    end
    test_count++;
    if (cap_fs_nl_last !== 1'b1) begin
      fail_count++; $display("FAIL nolz_frame_start got %b expected 1", cap_fs_nl_last);
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t        e;
    logic [3:0]  one = 4'b0001;
    logic [3:0]  exp_en;
    logic [6:0]  exp_seg;
    logic        exp_fs;
    int unsigned slot;
    capture_frame(3, 16'h5555, 0, 16'h0000);
    for (int unsigned k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 8) begin
        test_count++;
        if (segments !== 7'h12) begin
          fail_count++; $display("FAIL pre_reset_digit0 got %h expected 12", segments);
        end
      end
      data_valid = (k == 5);
      if (k == 5) data = 16'h9999;
      if (k == 19) rst = 1'b1;
    end
    @(negedge clk);
    test_count++;
    if (segments !== 7'h7F || digit_en !== 4'hF || frame_start !== 1'b0) begin
      fail_count++;
      $display("FAIL in_reset got seg %h en %b fs %b expected seg 7f en 1111 fs 0", segments, digit_en, frame_start);
    end
    rst = 1'b0;
    for (int unsigned c = 0; c < 32; c++) begin
      @(negedge clk);
      slot    = c / 8;
      exp_en  = ((c % 8) < 2) ? 4'hF : ~(one << slot);
      exp_seg = (slot == 0) ? 7'h40 : 7'h7F;
      exp_fs  = (c == 31);
      test_count++;
      if (digit_en !== exp_en || segments !== exp_seg || frame_start !== exp_fs) begin
        fail_count++;
        $display("FAIL post_reset cycle %0d got seg %h en %b fs %b expected seg %h en %b fs %b",
                 c, segments, digit_en, frame_start, exp_seg, exp_en, exp_fs);
      end
    end
    exp_q.push_back('{name: "pend_lost", segs: {7'h7F, 7'h7F, 7'h7F, 7'h40}});
    capture_frame(0, 16'h0000, 0, 16'h0000);
    e = exp_q.pop_front();
    for (int unsigned d = 0; d < 4; d++) begin
      test_count++;
      if (cap_seg[d] !== e.segs[7*d +: 7]) begin
        fail_count++; $display("FAIL %s digit%0d segments got %h expected %h", e.name, d, cap_seg[d], e.segs[7*d +: 7]);
      end
    end
    test_count++;
    if (cap_fs_count !== 1 || cap_fs_last !== 1'b1) begin
      fail_count++; $display("FAIL post_reset_fs pulses got %0d last %b expected 1 last 1", cap_fs_count, cap_fs_last);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mid_frame_update();
    test_last_strobe_wins();
    test_wrap_cycle_strobe();
    test_lz_blank();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
